fc_weight_fetcher: RTL and testbench

//  Read-side initiator for the FC weight memory. On start, walks the address

---
 rtl/fc_pkg.sv | 18 +
 rtl/fc_fetch_skid.sv | 55 +++++
 rtl/fc_weight_fetcher.sv | 158 +++++++++++++++
 tb/tb_fc_weight_fetcher.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the FC weight fetch path: default geometry of the
// weight memory, the derived word width and the fetcher FSM state encoding.
package fc_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int ADDR_WIDTH     = 9;
    localparam int PARALLEL_FC_PE = 32;
    localparam int FC_COLUMNS     = 100;
    localparam int WORD_WIDTH     = DATA_WIDTH * PARALLEL_FC_PE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fc_fetch_skid.sv
// Two-entry FIFO that holds captured weight words (data plus last flag)
// between the memory read port and the PE-array stream. The head entry is
// presented combinationally; push and pop may happen in the same cycle.
module fc_fetch_skid #(
    parameter int WIDTH = fc_pkg::WORD_WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entries [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // Storage, pointers and occupancy update on each handshake.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is assigned with <= so every flop samples
        // pre-edge values, independent of statement order.
        if (reset) begin
            // NOTE: the storage is reset here because the head entry drives
            // the weight bus directly and must read as zero out of reset.
            for (int i = 0; i < 2; i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = entries[rd_ptr];
    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);

endmodule

// File: rtl/fc_weight_fetcher.sv
// Read-side initiator for the FC weight memory. On start it walks addresses
// 0..FC_COLUMNS-1, captures each multi-lane weight word returned by the
// memory and streams it to the FC PE array over valid/ready.
// Optional feature macro: FC_FETCH_PERF_EN adds perf_cycles/perf_stalls
// counters and ports.
module fc_weight_fetcher #(
    parameter int DATA_WIDTH     = fc_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH     = fc_pkg::ADDR_WIDTH,
    parameter int PARALLEL_FC_PE = fc_pkg::PARALLEL_FC_PE,
    parameter int FC_COLUMNS     = fc_pkg::FC_COLUMNS
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
`ifdef FC_FETCH_PERF_EN
    output logic [31:0]                          perf_cycles,
    output logic [31:0]                          perf_stalls,
`endif
    output logic [ADDR_WIDTH-1:0]                address_fc,
    output logic                                 read_en_MM_fc,
    output logic                                 enable_MM_out_fc,
    input  logic [DATA_WIDTH*PARALLEL_FC_PE-1:0] dataMainMemo_fc,
    output logic [DATA_WIDTH*PARALLEL_FC_PE-1:0] w_data,
    output logic                                 w_valid,
    input  logic                                 w_ready,
    output logic                                 w_last
);

    import fc_pkg::*;

    localparam int                  WORD_W    = DATA_WIDTH * PARALLEL_FC_PE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FC_COLUMNS - 1);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  start_accept;
    logic                  issue;
    logic                  is_last_addr;
    logic                  pop;
    logic                  skid_full;
    logic                  skid_empty;
    logic [1:0]            skid_count;
    logic [WORD_W:0]       skid_head;

    assign start_accept = (state == IDLE) && start;
    assign is_last_addr = (addr == LAST_ADDR);

    // The memory answers within the issue cycle and the word is pushed on the
    // closing edge, so no read is ever outstanding when the next issue is
    // decided: skid occupancy alone bounds the reads.
    assign issue = (state == FETCH) && !skid_full;
    assign pop   = w_valid && w_ready;

    fc_fetch_skid #(
        .WIDTH (WORD_W + 1)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (issue),
        .push_data ({is_last_addr, dataMainMemo_fc}),
        .pop       (pop),
        .pop_data  (skid_head),
        .full      (skid_full),
        .empty     (skid_empty),
        .count     (skid_count)
    );

    assign w_valid    = !skid_empty;
    assign w_data     = skid_head[WORD_W-1:0];
    assign w_last     = w_valid && skid_head[WORD_W];
    assign address_fc = addr;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and memory/handshake control outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would infer a latch.
        state_next       = state;
        busy             = 1'b0;
        done             = 1'b0;
        read_en_MM_fc    = 1'b0;
        enable_MM_out_fc = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busy             = 1'b1;
                enable_MM_out_fc = 1'b1;
                read_en_MM_fc    = issue;
                if (issue && is_last_addr) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy             = 1'b1;
                enable_MM_out_fc = 1'b1;
                // Leave as soon as the final word is handshaken so done
                // follows the last transfer by exactly one cycle.
                if (skid_empty || ((skid_count == 2'd1) && pop)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read address counter: restarts at 0 on each pass, stops on the last word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
        end else if (start_accept) begin
            addr <= '0;
        end else if (issue && !is_last_addr) begin
            addr <= addr + 1'b1;
        end
    end

`ifdef FC_FETCH_PERF_EN
    // Busy-cycle and output-stall counters, cleared on each accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (start_accept) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (w_valid && !w_ready) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fc_weight_fetcher.sv
// Directed bench for fc_weight_fetcher. Instance dut_a runs a 4-word pass,
// instance dut_b a 100-word pass; each has a behavioural weight memory whose
// word k holds lane l = k*100 + l. With FC_FETCH_PERF_EN defined the perf
// counters are checked as well.
module tb_fc_weight_fetcher;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int PE = 32;
    localparam int WW = DW * PE;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- instance A (4 words) ----------------
    logic          start_a   = 1'b0;
    logic          w_ready_a = 1'b0;
    logic          busy_a, done_a, read_en_a, en_a, w_valid_a, w_last_a;
    logic [AW-1:0] addr_a;
    logic [WW-1:0] mem_a = '0;
    logic [WW-1:0] w_data_a;
`ifdef FC_FETCH_PERF_EN
    logic [31:0]   perf_cycles_a, perf_stalls_a;
    logic [31:0]   perf_cycles_b, perf_stalls_b;
`endif

    // ---------------- instance B (100 words) --------------
    logic          start_b   = 1'b0;
    logic          w_ready_b = 1'b0;
    logic          busy_b, done_b, read_en_b, en_b, w_valid_b, w_last_b;
    logic [AW-1:0] addr_b;
    logic [WW-1:0] mem_b = '0;
    logic [WW-1:0] w_data_b;

    always #5 clk = ~clk;

    fc_weight_fetcher #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARALLEL_FC_PE(PE), .FC_COLUMNS(4)
    ) dut_a (
        .clk              (clk),
        .reset            (reset),
        .start            (start_a),
        .busy             (busy_a),
        .done             (done_a),
`ifdef FC_FETCH_PERF_EN
        .perf_cycles      (perf_cycles_a),
        .perf_stalls      (perf_stalls_a),
`endif
        .address_fc       (addr_a),
        .read_en_MM_fc    (read_en_a),
        .enable_MM_out_fc (en_a),
        .dataMainMemo_fc  (mem_a),
        .w_data           (w_data_a),
        .w_valid          (w_valid_a),
        .w_ready          (w_ready_a),
        .w_last           (w_last_a)
    );

    fc_weight_fetcher #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARALLEL_FC_PE(PE), .FC_COLUMNS(100)
    ) dut_b (
        .clk              (clk),
        .reset            (reset),
        .start            (start_b),
        .busy             (busy_b),
        .done             (done_b),
`ifdef FC_FETCH_PERF_EN
        .perf_cycles      (perf_cycles_b),
        .perf_stalls      (perf_stalls_b),
`endif
        .address_fc       (addr_b),
        .read_en_MM_fc    (read_en_b),
        .enable_MM_out_fc (en_b),
        .dataMainMemo_fc  (mem_b),
        .w_data           (w_data_b),
        .w_valid          (w_valid_b),
        .w_ready          (w_ready_b),
        .w_last           (w_last_b)
    );

    function automatic logic [WW-1:0] word_of(input int k);
        logic [WW-1:0] w;
        w = '0;
        for (int l = 0; l < PE; l++) begin
            w[l*DW +: DW] = DW'(k * 100 + l);
        end
        return w;
    endfunction

    // Weight memories: sample the address on the falling edge of a read cycle.
    always @(negedge clk) begin
        if (read_en_a) mem_a <= word_of(int'(addr_a));
        if (read_en_b) mem_b <= word_of(int'(addr_b));
    end

    // Monitors: sampled mid-cycle, so a valid&ready seen here completes at the
    // next rising edge. Only these blocks write the monitor variables.
    int            done_cnt_a = 0, issue_cnt_a = 0, busy_cnt_a = 0;
    int            done_cnt_b = 0;
    logic [WW-1:0] got_a[$];
    logic          lastq_a[$];
    logic [WW-1:0] got_b[$];
    logic          lastq_b[$];
    logic [AW-1:0] addrq_b[$];

    always @(negedge clk) begin
        if (w_valid_a && w_ready_a) begin
            got_a.push_back(w_data_a);
            lastq_a.push_back(w_last_a);
        end
        if (done_a)    done_cnt_a++;
        if (read_en_a) issue_cnt_a++;
        if (busy_a)    busy_cnt_a++;
        if (w_valid_b && w_ready_b) begin
            got_b.push_back(w_data_b);
            lastq_b.push_back(w_last_b);
        end
        if (done_b)    done_cnt_b++;
        if (read_en_b) addrq_b.push_back(addr_b);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed low64 %h expected low64 %h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    initial begin
        int base_hs, base_done, base_issue, base_busy, base_addr, n;
        bit timeout;

        // ---------------- reset values ----------------
        repeat (3) tick();
        check("rst_busy",    busy_b,    1'b0);
        check("rst_done",    done_b,    1'b0);
        check("rst_addr",    addr_b,    '0);
        check("rst_read_en", read_en_b, 1'b0);
        check("rst_mem_en",  en_b,      1'b0);
        check("rst_w_valid", w_valid_b, 1'b0);
        check("rst_w_last",  w_last_b,  1'b0);
        check_word("rst_w_data", w_data_b, '0);
        reset = 1'b0;
        tick();

        // ---------------- A: full-rate 4-word pass ----------------
        w_ready_a = 1'b1;
        start_a   = 1'b1;
        tick();
        start_a   = 1'b0;
        check("t1_busy",    busy_a,    1'b1);
        check("t1_read_en", read_en_a, 1'b1);
        check("t1_addr0",   addr_a,    9'd0);
        check("t1_mem_en",  en_a,      1'b1);
        check("t1_nvalid",  w_valid_a, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t1_valid%0d", k), w_valid_a, 1'b1);
            check_word($sformatf("t1_data%0d", k), w_data_a, word_of(k));
            check($sformatf("t1_last%0d", k), w_last_a, (k == 3));
            check($sformatf("t1_rd%0d", k), read_en_a, (k < 3));
        end
        tick();
        check("t1_done",    done_a,    1'b1);
        check("t1_busy_lo", busy_a,    1'b0);
        check("t1_en_lo",   en_a,      1'b0);
        check("t1_vld_lo",  w_valid_a, 1'b0);
        tick();
        check("t1_done_lo", done_a,    1'b0);

        // ---------------- A: 10-cycle back-pressure ----------------
        base_hs    = got_a.size();
        base_done  = done_cnt_a;
        base_issue = issue_cnt_a;
        w_ready_a  = 1'b0;
        start_a    = 1'b1;
        tick();
        start_a    = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t2_hold_vld%0d", i), w_valid_a, 1'b1);
            check_word($sformatf("t2_hold_data%0d", i), w_data_a, word_of(0));
            tick();
        end
        check("t2_reads_during_stall", issue_cnt_a - base_issue, 2);
        w_ready_a = 1'b1;
        n = 0;
        timeout = 0;
        while (done_cnt_a == base_done) begin
            if (n >= 50) begin timeout = 1; break; end
            tick();
            n++;
        end
        check("t2_timeout", timeout, 1'b0);
        check("t2_count", got_a.size() - base_hs, 4);
        for (int k = 0; k < 4 && base_hs + k < got_a.size(); k++) begin
            check_word($sformatf("t2_data%0d", k), got_a[base_hs + k], word_of(k));
            check($sformatf("t2_last%0d", k), lastq_a[base_hs + k], (k == 3));
        end

        // ------- B: 100 words, w_ready 1010..., extra starts at 3 and 5 -------
        base_hs   = got_b.size();
        base_done = done_cnt_b;
        base_addr = addrq_b.size();
        w_ready_b = 1'b1;
        start_b   = 1'b1;
        tick();
        n = 1;
        timeout = 0;
        while (done_cnt_b == base_done) begin
            if (n >= 1000) begin timeout = 1; break; end
            start_b   = (n == 3) || (n == 5);
            w_ready_b = ~n[0];
            tick();
            n++;
        end
        start_b = 1'b0;
        w_ready_b = 1'b1;
        repeat (5) tick();
        check("t3_timeout", timeout, 1'b0);
        check("t3_count", got_b.size() - base_hs, 100);
        check("t3_reads", addrq_b.size() - base_addr, 100);
        check("t3_done_pulses", done_cnt_b - base_done, 1);
        check("t3_busy_after", busy_b, 1'b0);
        for (int k = 0; k < 100 && base_hs + k < got_b.size(); k++) begin
            check_word($sformatf("t3_data%0d", k), got_b[base_hs + k], word_of(k));
            check($sformatf("t3_last%0d", k), lastq_b[base_hs + k], (k == 99));
        end
        for (int k = 0; k < 100 && base_addr + k < addrq_b.size(); k++) begin
            check($sformatf("t3_addr%0d", k), addrq_b[base_addr + k], AW'(k));
        end

        // ---------------- B: reset at word 50, then a fresh pass ----------------
        base_hs = got_b.size();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        timeout = 0;
        while (got_b.size() - base_hs < 50) begin
            if (n >= 200) begin timeout = 1; break; end
            tick();
            n++;
        end
        check("t5_reach50", timeout, 1'b0);
        reset = 1'b1;
        tick();
        check("t5_busy",    busy_b,    1'b0);
        check("t5_done",    done_b,    1'b0);
        check("t5_addr",    addr_b,    '0);
        check("t5_read_en", read_en_b, 1'b0);
        check("t5_mem_en",  en_b,      1'b0);
        check("t5_w_valid", w_valid_b, 1'b0);
        check("t5_w_last",  w_last_b,  1'b0);
        check_word("t5_w_data", w_data_b, '0);
        reset = 1'b0;
        tick();
        base_hs   = got_b.size();
        base_done = done_cnt_b;
        start_b   = 1'b1;
        tick();
        start_b   = 1'b0;
        check("t5_restart_rd",   read_en_b, 1'b1);
        check("t5_restart_addr", addr_b,    9'd0);
        n = 0;
        timeout = 0;
        while (done_cnt_b == base_done) begin
            if (n >= 300) begin timeout = 1; break; end
            tick();
            n++;
        end
        check("t5_timeout", timeout, 1'b0);
        check("t5_count", got_b.size() - base_hs, 100);
        if (got_b.size() - base_hs >= 100) begin
            check_word("t5_first", got_b[base_hs], word_of(0));
            check_word("t5_final", got_b[base_hs + 99], word_of(99));
        end

`ifdef FC_FETCH_PERF_EN
        // ---------------- A: perf counters with 3 stall cycles ----------------
        tick();
        base_busy = busy_cnt_a;
        base_done = done_cnt_a;
        w_ready_a = 1'b0;
        start_a   = 1'b1;
        tick();
        start_a   = 1'b0;
        repeat (4) tick();
        w_ready_a = 1'b1;
        n = 0;
        timeout = 0;
        while (done_cnt_a == base_done) begin
            if (n >= 50) begin timeout = 1; break; end
            tick();
            n++;
        end
        repeat (2) tick();
        check("perf_timeout", timeout, 1'b0);
        check("perf_stalls", perf_stalls_a, 32'd3);
        check("perf_cycles", perf_cycles_a, 32'(busy_cnt_a - base_busy));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
